kf_hv_serializer: RTL and testbench
===================================

Name: kf_hv_serializer

Overview:
- Transmit side of the bit-serial hypervector datapath: takes word-parallel hypervector chunks from on-chip memory or a DMA and emits them LSB-first as a one-bit-per-cycle stream.
- Drives the bit_a_in/bit_b_in + bit_valid inputs of the holographic neuron array, and the thought/query inputs of the resonant stream.
- Generates vector framing: start, last, done, and the stream index.

Parameters:
- HYPERVEC_DIM, 8192, bits per hypervector; must be a multiple of WORD_WIDTH (elaboration-time assertion).
- WORD_WIDTH, 64, width of input words; power of two, ≥2.
- WORDS_PER_VEC, HYPERVEC_DIM/WORD_WIDTH, localparam, words per vector.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- word_data  in  WORD_WIDTH  next chunk; bit 0 is transmitted first
- word_valid  in  1  word_data valid
- word_ready  out  1  serializer can accept a word this cycle
- bit_en  in  1  downstream advance; a bit is consumed when bit_valid && bit_en
- abort  in  1  synchronous flush of the current vector
- bit_out  out  1  serial data bit
- bit_valid  out  1  bit_out valid
- bit_start  out  1  high with bit_valid on vector bit 0 (maps to thought_start/query_start)
- bit_last  out  1  high with bit_valid on vector bit HYPERVEC_DIM-1
- vec_done  out  1  one-cycle pulse, cycle after the last bit is consumed
- underrun  out  1  one-cycle pulse when the stream starves mid-vector
- busy  out  1  high whenever a vector is partially transmitted (stream_idx != 0) or data is held
- stream_idx  out  $clog2(HYPERVEC_DIM)  index of the bit currently presented

Behaviour:
- Reset values: word_ready=0 during reset, then 1 on the first cycle after reset. All other outputs are 0; shift and buffer registers are empty.
- Storage: one shift register (SR) plus bit counter, and one holding buffer (HB).
  - word_ready = !HB_full || (HB moves into SR this cycle).
  - Word handshake completes on word_valid && word_ready.
- States:
  - IDLE: SR empty, stream_idx=0.
  - STREAM: SR holds data.
  - STARVE: SR empty, stream_idx != 0.
- IDLE -> STREAM: the accepted word loads SR directly if HB is empty.
  - Word accepted at cycle t gives bit_valid=1 at t+1 (one-cycle latency).
- In STREAM: bit_out = SR[0].
  - On consume: SR shifts right, bit counter increments, stream_idx increments.
- SR refill, on consume of the SR's final bit (counter == WORD_WIDTH-1):
  - HB full: HB -> SR in the same edge; no bubble, and bit_valid stays 1.
  - HB empty but word handshake this cycle: the word loads SR directly; no bubble.
  - Otherwise: go to IDLE if stream_idx wrapped to 0, else STARVE. In STARVE, underrun pulses for 1 cycle and bit_valid=0.
- STARVE -> STREAM on the next accepted word; the stream resumes at the held stream_idx with no reframing.
- When bit_en=0, all outputs hold and no state changes. Word acceptance into HB is still allowed.
- Framing:
  - bit_start = bit_valid && stream_idx==0.
  - bit_last = bit_valid && stream_idx==HYPERVEC_DIM-1.
  - Consuming bit_last wraps stream_idx to 0, and vec_done=1 on the next cycle.
  - Back-to-back vectors run without a gap if data is available.
- abort has priority over everything, including a simultaneous word handshake (that word is dropped; word_ready=0 in the abort cycle).
  - Next cycle: SR/HB empty, stream_idx=0, IDLE, bit_valid=0.
  - No vec_done or underrun pulse is generated by an abort.
- Async reset mid-vector: immediate return to the reset values; no partial-vector recovery.
- Arithmetic: bit counter is $clog2(WORD_WIDTH) bits and wraps naturally. stream_idx is compared explicitly against HYPERVEC_DIM-1; it never exceeds that value.

Decomposition:
- Shared package kf_hdc_pkg:
  - HYPERVEC_DIM_DEFAULT.
  - The serializer state enum {ST_IDLE, ST_STREAM, ST_STARVE}.
  - An hv_idx_t typedef of width $clog2(HYPERVEC_DIM_DEFAULT).
- One natural sub-module: kf_hv_word_buffer, the single-entry holding register with valid/ready (skid) behaviour.
- The top level holds the SR, counters, FSM and framing.

Test Plan (WORD_WIDTH=8, HYPERVEC_DIM=32 unless noted):
- Reset, then 4 words 0x01,0x02,0x04,0x80 offered continuously, bit_en=1:
  - 32 consecutive bit_valid cycles, bit_out=1 at idx 0, 9, 18, 31.
  - bit_start at idx 0, bit_last at idx 31, vec_done one cycle after.
- Same stream with bit_en toggled 1,0,1,0…:
  - Identical bit sequence; outputs hold on bit_en=0 cycles.
  - 64 cycles to complete; vec_done pulses once.
- Word 1 withheld for 5 cycles after word 0 is consumed:
  - underrun pulses once at idx 8; bit_valid=0 for the gap.
  - Resumes at stream_idx=8 with bit_start=0.
- Assert abort at idx 13 with word_valid high:
  - Next cycle bit_valid=0, stream_idx=0, word_ready=1.
  - The next accepted word begins a fresh vector with bit_start=1; no vec_done or underrun is seen.
- Two vectors (8 words) streamed back-to-back:
  - No bit_valid gap; bit_last at cycle 32 immediately followed by bit_start.
  - vec_done twice.
- Default parameters (8192/64), 128 random words:
  - Serialized bits match the scoreboard.
  - stream_idx runs 0→8191 and back to 0; exactly one vec_done.

Source files
------------

// File: rtl/kf_hdc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : kf_hdc_pkg
//  Description : Shared hyperdimensional-computing types and defaults used by
//                the bit-serial hypervector datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package kf_hdc_pkg;

   localparam int HYPERVEC_DIM_DEFAULT = 8192;

   // Serializer control states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,   // shift register empty, stream index at 0
      ST_STREAM = 2'd1,   // shift register holds data
      ST_STARVE = 2'd2    // shift register empty mid-vector
   } ser_state_t;

   typedef logic [$clog2(HYPERVEC_DIM_DEFAULT)-1:0] hv_idx_t;

endpackage
`default_nettype wire

// File: rtl/kf_hv_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : kf_hv_serializer_if
//  Description : Word input handshake and serial bit output bundle of the
//                hypervector serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface kf_hv_serializer_if
   import kf_hdc_pkg::*;
#(
   parameter int WORD_WIDTH   = 64,
   parameter int HYPERVEC_DIM = HYPERVEC_DIM_DEFAULT
);
   logic [WORD_WIDTH-1:0]           word_data;
   logic                            word_valid;
   logic                            word_ready;
   logic                            bit_en;
   logic                            abort;
   logic                            bit_out;
   logic                            bit_valid;
   logic                            bit_start;
   logic                            bit_last;
   logic                            vec_done;
   logic                            underrun;
   logic                            busy;
   logic [$clog2(HYPERVEC_DIM)-1:0] stream_idx;

   // Word source / bit sink side
   modport master (
      output word_data, word_valid, bit_en, abort,
      input  word_ready, bit_out, bit_valid, bit_start, bit_last,
             vec_done, underrun, busy, stream_idx
   );

   // Serializer side
   modport slave (
      input  word_data, word_valid, bit_en, abort,
      output word_ready, bit_out, bit_valid, bit_start, bit_last,
             vec_done, underrun, busy, stream_idx
   );
endinterface
`default_nettype wire

// File: rtl/kf_hv_word_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : kf_hv_word_buffer
//  Description : Single-entry holding register with skid behaviour: it can
//                take a new word in the same cycle its current word leaves.
//  Revision    : 1.0 - initial release
// ============================================================================
module kf_hv_word_buffer #(
   parameter int WIDTH = 64
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             i_flush,
   input  wire logic             i_push_valid,
   input  wire logic [WIDTH-1:0] i_push_data,
   output logic                  o_push_ready,
   input  wire logic             i_pop,
   output logic                  o_pop_valid,
   output logic [WIDTH-1:0]      o_pop_data
);
   logic             r_full;
   logic [WIDTH-1:0] r_data;

   assign o_push_ready = !r_full || i_pop;
   assign o_pop_valid  = r_full;
   assign o_pop_data   = r_data;

   // Occupancy and data: flush beats push, push (possibly with pop) beats pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_full <= 1'b0;
         r_data <= '0;
      end else if (i_flush) begin
         r_full <= 1'b0;
      end else if (i_push_valid) begin
         r_full <= 1'b1;
         r_data <= i_push_data;
      end else if (i_pop) begin
         r_full <= 1'b0;
      end
   end
endmodule
`default_nettype wire

// File: rtl/kf_hv_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : kf_hv_serializer
//  Description : Word-parallel to bit-serial hypervector transmitter with
//                start/last/done framing and starvation detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module kf_hv_serializer
   import kf_hdc_pkg::*;
#(
   parameter int HYPERVEC_DIM = HYPERVEC_DIM_DEFAULT,
   parameter int WORD_WIDTH   = 64
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   kf_hv_serializer_if.slave  s_bus
);
   localparam int WORDS_PER_VEC = HYPERVEC_DIM / WORD_WIDTH;
   localparam int c_cnt_w       = $clog2(WORD_WIDTH);
   localparam int c_idx_w       = $clog2(HYPERVEC_DIM);
   localparam logic [c_cnt_w-1:0] c_bcnt_last = c_cnt_w'(WORD_WIDTH - 1);
   localparam logic [c_idx_w-1:0] c_idx_last  = c_idx_w'(HYPERVEC_DIM - 1);

   generate
      if ((WORD_WIDTH < 2) || ((WORD_WIDTH & (WORD_WIDTH - 1)) != 0)) begin : g_bad_word_width
         $error("kf_hv_serializer: WORD_WIDTH must be a power of two >= 2");
      end
      if ((WORDS_PER_VEC < 1) || (WORDS_PER_VEC * WORD_WIDTH != HYPERVEC_DIM)) begin : g_bad_dim
         $error("kf_hv_serializer: HYPERVEC_DIM must be a multiple of WORD_WIDTH");
      end
   endgenerate

   ser_state_t              r_state;
   ser_state_t              w_state_next;
   logic [WORD_WIDTH-1:0]   r_sr;
   logic [c_cnt_w-1:0]      r_bcnt;
   logic [c_idx_w-1:0]      r_idx;
   logic                    r_vec_done;
   logic                    r_underrun;
   logic                    r_live;

   logic                    w_consume, w_word_end, w_sr_free, w_sr_load;
   logic                    w_hs, w_direct, w_word_ready;
   logic                    w_hb_full, w_hb_pop, w_hb_push_ready;
   logic [WORD_WIDTH-1:0]   w_hb_data;
   logic [c_idx_w-1:0]      w_idx_next;
   logic                    w_bit_valid, w_bit_start, w_bit_last, w_busy;

   // A bit leaves only when presented and the sink advances; the SR is free
   // to reload when its final bit leaves, or when empty and the sink is live.
   assign w_consume    = (r_state == ST_STREAM) && s_bus.bit_en;
   assign w_word_end   = w_consume && (r_bcnt == c_bcnt_last);
   assign w_sr_free    = w_word_end || ((r_state != ST_STREAM) && s_bus.bit_en);
   assign w_hb_pop     = w_sr_free && w_hb_full && !s_bus.abort;
   assign w_word_ready = r_live && !s_bus.abort && w_hb_push_ready;
   assign w_hs         = s_bus.word_valid && w_word_ready;
   assign w_direct     = w_hs && w_sr_free && !w_hb_full;
   assign w_sr_load    = w_sr_free && (w_hb_full || w_hs);
   assign w_idx_next   = (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;

   kf_hv_word_buffer #(.WIDTH(WORD_WIDTH)) u_hb (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_flush      (s_bus.abort),
      .i_push_valid (w_hs && !w_direct),
      .i_push_data  (s_bus.word_data),
      .o_push_ready (w_hb_push_ready),
      .i_pop        (w_hb_pop),
      .o_pop_valid  (w_hb_full),
      .o_pop_data   (w_hb_data)
   );

   // Holds word_ready low until the first edge after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_live <= 1'b0;
      else        r_live <= 1'b1;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   // Next state: abort flushes, any reload streams, an unrefilled word end
   // idles on a vector boundary and starves otherwise
   always_comb begin
      w_state_next = r_state;
      if (s_bus.abort)     w_state_next = ST_IDLE;
      else if (w_sr_load)  w_state_next = ST_STREAM;
      else if (w_word_end) w_state_next = (w_idx_next == '0) ? ST_IDLE : ST_STARVE;
   end

   // Framing and status decoded from state and stream index
   always_comb begin
      w_bit_valid = (r_state == ST_STREAM);
      w_bit_start = w_bit_valid && (r_idx == '0);
      w_bit_last  = w_bit_valid && (r_idx == c_idx_last);
      w_busy      = (r_idx != '0) || (r_state == ST_STREAM) || w_hb_full;
   end

   // Shift register, counters and one-cycle event pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sr       <= '0;
         r_bcnt     <= '0;
         r_idx      <= '0;
         r_vec_done <= 1'b0;
         r_underrun <= 1'b0;
      end else if (s_bus.abort) begin
         r_sr       <= '0;
         r_bcnt     <= '0;
         r_idx      <= '0;
         r_vec_done <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_vec_done <= w_consume && (r_idx == c_idx_last);
         r_underrun <= w_word_end && !w_sr_load && (w_idx_next != '0);
         if (w_consume) r_idx <= w_idx_next;
         if (w_sr_load) begin
            r_sr   <= w_hb_full ? w_hb_data : s_bus.word_data;
            r_bcnt <= '0;
         end else if (w_consume) begin
            r_sr   <= r_sr >> 1;
            r_bcnt <= r_bcnt + 1'b1;
         end
      end
   end

   assign s_bus.word_ready = w_word_ready;
   assign s_bus.bit_out    = r_sr[0];
   assign s_bus.bit_valid  = w_bit_valid;
   assign s_bus.bit_start  = w_bit_start;
   assign s_bus.bit_last   = w_bit_last;
   assign s_bus.vec_done   = r_vec_done;
   assign s_bus.underrun   = r_underrun;
   assign s_bus.busy       = w_busy;
   assign s_bus.stream_idx = r_idx;
endmodule
`default_nettype wire

// File: tb/tb_kf_hv_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_kf_hv_serializer
//  Description : Self-checking bench for kf_hv_serializer; a small (8/32)
//                and a default (64/8192) instance share the stimulus, and a
//                bit-queue reference model predicts the serial stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_kf_hv_serializer;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        sel;
   logic [63:0] tb_data;
   logic        tb_valid, tb_en, tb_abort;

   kf_hv_serializer_if #(.WORD_WIDTH(8), .HYPERVEC_DIM(32)) if_s ();
   kf_hv_serializer_if if_d ();

   assign if_s.word_data  = tb_data[7:0];
   assign if_s.word_valid = tb_valid && !sel;
   assign if_s.bit_en     = tb_en && !sel;
   assign if_s.abort      = tb_abort && !sel;
   assign if_d.word_data  = tb_data;
   assign if_d.word_valid = tb_valid && sel;
   assign if_d.bit_en     = tb_en && sel;
   assign if_d.abort      = tb_abort && sel;

   kf_hv_serializer #(.HYPERVEC_DIM(32), .WORD_WIDTH(8)) dut_s (
      .clk(clk), .rst_n(rst_n), .s_bus(if_s));
   kf_hv_serializer dut_d (
      .clk(clk), .rst_n(rst_n), .s_bus(if_d));

   logic        w_ready, w_bit, w_valid, w_start, w_last, w_done, w_und, w_busy;
   logic [12:0] w_idx;
   assign w_ready = sel ? if_d.word_ready : if_s.word_ready;
   assign w_bit   = sel ? if_d.bit_out    : if_s.bit_out;
   assign w_valid = sel ? if_d.bit_valid  : if_s.bit_valid;
   assign w_start = sel ? if_d.bit_start  : if_s.bit_start;
   assign w_last  = sel ? if_d.bit_last   : if_s.bit_last;
   assign w_done  = sel ? if_d.vec_done   : if_s.vec_done;
   assign w_und   = sel ? if_d.underrun   : if_s.underrun;
   assign w_busy  = sel ? if_d.busy       : if_s.busy;
   assign w_idx   = sel ? 13'(if_d.stream_idx) : 13'(if_s.stream_idx);

   // reference model: every accepted word's bits, oldest first
   bit          exp_q[$];
   logic [63:0] src_q[$];
   int          ones_q[$];
   int          m_idx, dim, ww;
   bit          done_pend, und_pend, prev_en, prev_valid, prev_abort, post_abort_chk;
   int          n_checks, n_errors;
   int          n_done, n_und, n_cons, n_valid, cyc, first_valid_cyc, last_cons_cyc;
   int          b2b_cnt, und_idx, max_idx;
   int          en_mode, en_phase, valid_pct, abort_permille;
   bit          abort_req;
   int          exp_ones[4];

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      exp_q.delete(); src_q.delete(); ones_q.delete();
      m_idx = 0; done_pend = 0; und_pend = 0; prev_en = 0; prev_valid = 0;
      prev_abort = 0; post_abort_chk = 0;
      n_done = 0; n_und = 0; n_cons = 0; n_valid = 0; cyc = 0;
      first_valid_cyc = -1; last_cons_cyc = -10; b2b_cnt = 0; und_idx = -1; max_idx = 0;
      en_mode = 0; en_phase = 0; valid_pct = 100; abort_permille = 0; abort_req = 0;
   endtask

   task automatic do_reset(input bit s);
      sel = s; dim = s ? 8192 : 32; ww = s ? 64 : 8;
      tb_valid = 0; tb_en = 0; tb_abort = 0; tb_data = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_word_ready", 64'(w_ready), 64'(0));
      check_eq("rst_bit_valid",  64'(w_valid), 64'(0));
      check_eq("rst_bit_out",    64'(w_bit),   64'(0));
      check_eq("rst_framing",    64'({w_start, w_last, w_done, w_und}), 64'(0));
      check_eq("rst_busy",       64'(w_busy),  64'(0));
      check_eq("rst_stream_idx", 64'(w_idx),   64'(0));
      @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("ready_after_rst", 64'(w_ready), 64'(1));
      @(posedge clk); #1;
      model_reset();
   endtask

   // one clock: drive, sample and check at negedge, update the model
   task automatic step();
      bit consumed, exp_valid;
      case (en_mode)
         0:       tb_en = 1'b1;
         1:       tb_en = (en_phase % 2 == 0);
         default: tb_en = ($urandom_range(3) != 0);
      endcase
      en_phase++;
      if (src_q.size() > 0 && $urandom_range(99) < valid_pct) begin
         tb_valid = 1'b1; tb_data = src_q[0];
      end else begin
         tb_valid = 1'b0; tb_data = {$urandom, $urandom};
      end
      tb_abort = abort_req || ($urandom_range(999) < abort_permille);

      @(negedge clk);
      cyc++;
      exp_valid = prev_abort ? 1'b0 : (prev_en ? (exp_q.size() > 0) : prev_valid);
      check_eq("bit_valid",  64'(w_valid), 64'(exp_valid));
      check_eq("vec_done",   64'(w_done),  64'(done_pend));
      check_eq("underrun",   64'(w_und),   64'(und_pend));
      check_eq("stream_idx", 64'(w_idx),   64'(m_idx));
      check_eq("busy",       64'(w_busy),  64'((m_idx != 0) || (exp_q.size() > 0)));
      if (post_abort_chk) begin
         check_eq("post_abort_ready", 64'(w_ready), 64'(1));
         post_abort_chk = 0;
      end
      if (exp_q.size() == 0 && !tb_abort) check_eq("ready_when_empty", 64'(w_ready), 64'(1));
      if (w_done) n_done++;
      if (w_und) begin n_und++; und_idx = int'(w_idx); end
      if (w_valid) begin
         n_valid++;
         if (first_valid_cyc < 0) first_valid_cyc = cyc;
         if (int'(w_idx) > max_idx) max_idx = int'(w_idx);
         if (exp_q.size() > 0) check_eq("bit_out", 64'(w_bit), 64'(exp_q[0]));
         check_eq("bit_start", 64'(w_start), 64'(m_idx == 0));
         check_eq("bit_last",  64'(w_last),  64'(m_idx == dim - 1));
         if (w_start && cyc == last_cons_cyc + 1) b2b_cnt++;
      end else begin
         check_eq("idle_framing", 64'({w_start, w_last}), 64'(0));
      end

      done_pend = 0; consumed = 0;
      if (w_valid && tb_en && exp_q.size() > 0) begin
         if (exp_q[0]) ones_q.push_back(m_idx);
         void'(exp_q.pop_front());
         if (m_idx == dim - 1) begin done_pend = 1; last_cons_cyc = cyc; end
         m_idx = (m_idx + 1) % dim;
         consumed = 1; n_cons++;
      end
      if (tb_valid && w_ready) begin
         for (int i = 0; i < ww; i++) exp_q.push_back(tb_data[i]);
         void'(src_q.pop_front());
      end
      if (tb_abort) begin
         check_eq("abort_ready", 64'(w_ready), 64'(0));
         exp_q.delete(); m_idx = 0; done_pend = 0; post_abort_chk = 1;
      end
      und_pend   = consumed && (exp_q.size() == 0) && (m_idx != 0) && !tb_abort;
      prev_en    = tb_en;
      prev_valid = w_valid;
      prev_abort = tb_abort;
      @(posedge clk); #1;
   endtask

   task automatic run_until_done(input int n, input int limit);
      int k;
      k = 0;
      while (n_done < n && k < limit) begin step(); k++; end
      if (n_done < n) check_eq("timeout_vec_done", 64'(n_done), 64'(n));
      repeat (3) step();
   endtask

   task automatic check_ones(input string tag);
      check_eq({tag, "_ones_cnt"}, 64'(ones_q.size()), 64'(4));
      if (ones_q.size() == 4)
         for (int i = 0; i < 4; i++) check_eq({tag, "_one_idx"}, 64'(ones_q[i]), 64'(exp_ones[i]));
   endtask

   initial begin
      int k;
      n_checks = 0; n_errors = 0;
      exp_ones = '{0, 9, 18, 31};
      model_reset();

      // 1: single vector, continuous data and sink
      do_reset(0);
      src_q = '{64'h01, 64'h02, 64'h04, 64'h80};
      run_until_done(1, 200);
      check_eq("t1_valid_cycles", 64'(n_valid), 64'(32));
      check_eq("t1_span", 64'(last_cons_cyc - first_valid_cyc), 64'(31));
      check_eq("t1_vec_done", 64'(n_done), 64'(1));
      check_ones("t1");

      // 2: same vector, sink advancing every other cycle
      do_reset(0);
      en_mode = 1;
      src_q = '{64'h01, 64'h02, 64'h04, 64'h80};
      run_until_done(1, 300);
      check_eq("t2_valid_cycles", 64'(n_valid), 64'(64));
      check_eq("t2_span", 64'(last_cons_cyc - first_valid_cyc), 64'(63));
      check_eq("t2_vec_done", 64'(n_done), 64'(1));
      check_ones("t2");

      // 3: second word withheld for 5 cycles after the first drains
      do_reset(0);
      src_q = '{64'h5A};
      k = 0;
      while (n_cons < 8 && k < 100) begin step(); k++; end
      check_eq("t3_first_word", 64'(n_cons), 64'(8));
      repeat (5) step();
      src_q = '{64'h3C, 64'hFF, 64'h81};
      run_until_done(1, 200);
      check_eq("t3_underrun_cnt", 64'(n_und), 64'(1));
      check_eq("t3_underrun_idx", 64'(und_idx), 64'(8));
      check_eq("t3_span", 64'(last_cons_cyc - first_valid_cyc), 64'(37));

      // 4: abort at index 13 while a word is offered
      do_reset(0);
      for (int i = 0; i < 8; i++) src_q.push_back(64'($urandom_range(255)));
      k = 0;
      while (!(w_valid && w_idx == 13'd13) && k < 100) begin step(); k++; end
      check_eq("t4_reach_idx13", 64'(w_idx), 64'(13));
      abort_req = 1'b1;
      step();
      abort_req = 1'b0;
      run_until_done(1, 200);
      check_eq("t4_vec_done", 64'(n_done), 64'(1));
      check_eq("t4_underrun", 64'(n_und), 64'(0));

      // 5: two vectors back to back
      do_reset(0);
      for (int i = 0; i < 8; i++) src_q.push_back(64'($urandom_range(255)));
      run_until_done(2, 300);
      check_eq("t5_valid_cycles", 64'(n_valid), 64'(64));
      check_eq("t5_span", 64'(last_cons_cyc - first_valid_cyc), 64'(63));
      check_eq("t5_last_to_start", 64'(b2b_cnt), 64'(1));
      check_eq("t5_vec_done", 64'(n_done), 64'(2));

      // 6: random data, sink, source gaps and aborts on the small instance
      do_reset(0);
      en_mode = 2; valid_pct = 80; abort_permille = 15;
      for (int i = 0; i < 40; i++) src_q.push_back(64'($urandom_range(255)));
      repeat (700) step();

      // 7: default parameters, one full 8192-bit vector of random words
      do_reset(1);
      en_mode = 2; valid_pct = 90;
      for (int i = 0; i < 128; i++) src_q.push_back({$urandom, $urandom});
      run_until_done(1, 40000);
      check_eq("t7_vec_done", 64'(n_done), 64'(1));
      check_eq("t7_bits", 64'(n_cons), 64'(8192));
      check_eq("t7_max_idx", 64'(max_idx), 64'(8191));
      check_eq("t7_idx_wrap", 64'(w_idx), 64'(0));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
